trivium_keystream_gen: RTL and testbench



---
 rtl/trivium_keystream_gen_if.sv | 20 ++
 rtl/trivium_keystream_gen.sv | 106 ++++++++++
 tb/tb_trivium_keystream_gen.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/trivium_keystream_gen_if.sv
// Key/IV load port and valid/ready keystream byte stream of the Trivium generator.
interface trivium_keystream_gen_if;
  logic [79:0] key_in;
  logic [79:0] iv_in;
  logic        load;
  logic        busy;
  logic [7:0]  ks_byte;
  logic        ks_valid;
  logic        ks_ready;

  modport master (
    input  key_in, iv_in, load, ks_ready,
    output busy, ks_byte, ks_valid
  );

  modport slave (
    output key_in, iv_in, load, ks_ready,
    input  busy, ks_byte, ks_valid
  );
endinterface

// File: rtl/trivium_keystream_gen.sv
// Trivium keystream generator: 8 chained steps per clock, 1152-step warm-up,
// then one keystream byte per valid/ready transfer. Bit s(i) lives at index i-1.
module trivium_step (
  input  logic [287:0] s_i,
  output logic [287:0] s_o,
  output logic         z_o
);
  logic l1, l2, l3;
  logic t1, t2, t3;

  assign l1  = s_i[65]  ^ s_i[92];
  assign l2  = s_i[161] ^ s_i[176];
  assign l3  = s_i[242] ^ s_i[287];
  assign z_o = l1 ^ l2 ^ l3;

  assign t1 = l1 ^ (s_i[90]  & s_i[91])  ^ s_i[170];
  assign t2 = l2 ^ (s_i[174] & s_i[175]) ^ s_i[263];
  assign t3 = l3 ^ (s_i[285] & s_i[286]) ^ s_i[68];

  // Each of the three registers shifts up by one, feedback entering at its low end.
  assign s_o = {s_i[286:177], t2, s_i[175:93], t1, s_i[91:0], t3};
endmodule

module trivium_keystream_gen #(
  parameter int WARMUP_CYCLES = 144,
  parameter int CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  trivium_keystream_gen_if.master ks
);
  localparam int STEPS = 8;
  localparam int SW    = 288;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_e;

  state_e            st_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     s_q, s_d;
  logic [STEPS:0][SW-1:0] chain;
  logic [STEPS-1:0]  z;
  logic [SW-1:0]     load_vec;

  assign chain[0] = s_q;

  genvar g;
  generate
    for (g = 0; g < STEPS; g++) begin : g_step
      trivium_step u_step (
        .s_i (chain[g]),
        .s_o (chain[g+1]),
        .z_o (z[g])
      );
    end
  endgenerate

  // Key into s1..s80, IV into s94..s173, s286..s288 set, everything else clear.
  assign load_vec = {3'b111, 112'b0, ks.iv_in, 13'b0, ks.key_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      s_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      s_q   <= s_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    s_d   = s_q;
    if (ena) begin
      if (ks.load) begin
        // A transfer on the same edge is dropped: the state is overwritten.
        s_d   = load_vec;
        cnt_d = '0;
        st_d  = WARMUP;
      end else begin
        case (st_q)
          WARMUP: begin
            s_d   = chain[STEPS];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) st_d = RUN;
          end
          RUN: begin
            if (ks.ks_ready) s_d = chain[STEPS];
          end
          default: ;
        endcase
      end
    end
  end

  assign ks.busy     = (st_q == WARMUP);
  assign ks.ks_valid = (st_q == RUN);
  assign ks.ks_byte  = (st_q == RUN) ? z : 8'h00;
endmodule

// File: tb/tb_trivium_keystream_gen.sv
// Bench for trivium_keystream_gen: vector table checked against a bit-serial Trivium model.
module tb_trivium_keystream_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  int   total = 0;
  int   bad = 0;

  trivium_keystream_gen_if kif ();

  trivium_keystream_gen #(.WARMUP_CYCLES(144), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .ks    (kif)
  );

  always #5 clk = ~clk;

  typedef logic [63:0][7:0] bytes_t;

  typedef struct {
    logic [79:0] key;
    logic [79:0] iv;
    bit          tog;
    int          stall_at;
    int          stall_len;
    int          nb;
    bytes_t      exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain bit-serial Trivium over s[1..288], keystream packed LSB-first.
  function automatic bytes_t model(input logic [79:0] k, input logic [79:0] v);
    bit s [1:288];
    bit t1, t2, t3, z;
    bytes_t r = '0;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 0; i < 80; i++) begin
      s[i+1]  = k[i];
      s[94+i] = v[i];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    for (int n = 0; n < 1152 + 512; n++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 93; i >= 2; i--) s[i] = s[i-1];
      s[1] = t3;
      for (int i = 177; i >= 95; i--) s[i] = s[i-1];
      s[94] = t1;
      for (int i = 288; i >= 179; i--) s[i] = s[i-1];
      s[178] = t2;
      if (n >= 1152) r[(n-1152)/8][(n-1152)%8] = z;
    end
    return r;
  endfunction

  function automatic vec_t mkvec(input logic [79:0] k, input logic [79:0] v, input bit tog,
                                 input int sa, input int sl, input int nb);
    vec_t x;
    x.key = k; x.iv = v; x.tog = tog;
    x.stall_at = sa; x.stall_len = sl; x.nb = nb;
    x.exp = model(k, v);
    return x;
  endfunction

  // Load, then time the warm-up until ks_valid rises.
  task automatic start(input logic [79:0] k, input logic [79:0] v, input bit tog, input string tag);
    int n = 0;
    int nbusy = 0;
    bit both = 1'b0;
    bit zbad = 1'b0;
    kif.key_in = k; kif.iv_in = v; kif.load = 1'b1; ena = 1'b1;
    tick();
    kif.load = 1'b0;
    while (!kif.ks_valid && n < 1000) begin
      if (kif.busy) nbusy++;
      if (kif.ks_byte != 8'h00) zbad = 1'b1;
      ena = tog ? ~ena : 1'b1;
      tick();
      n++;
    end
    both = kif.busy & kif.ks_valid;
    chk({tag, " warmup_clocks"}, 64'(n), tog ? 64'd288 : 64'd144);
    chk({tag, " busy_clocks"}, 64'(nbusy), tog ? 64'd288 : 64'd144);
    chk({tag, " byte_zero_in_warmup"}, 64'(zbad), 64'd0);
    chk({tag, " busy_and_valid"}, 64'(both), 64'd0);
  endtask

  task automatic collect(input bytes_t exp, input int nb, input bit tog, input int sa,
                         input int sl, input string tag);
    int cyc = 0;
    int st = 0;
    logic [7:0] held = 8'h00;
    logic [7:0] got [$];
    while (got.size() < nb && cyc < 4000) begin
      ena = tog ? ~ena : 1'b1;
      if (kif.ks_valid && got.size() == sa && st < sl) begin
        if (st == 0) held = kif.ks_byte;
        else chk({tag, " stall_hold"}, 64'(kif.ks_byte), 64'(held));
        kif.ks_ready = 1'b0;
        st++;
      end else begin
        kif.ks_ready = 1'b1;
      end
      if (cyc < 3 * nb) chk({tag, " run_valid"}, 64'({kif.ks_valid, kif.busy}), 64'b10);
      if (kif.ks_valid && kif.ks_ready && ena) got.push_back(kif.ks_byte);
      tick();
      cyc++;
    end
    chk({tag, " byte_count"}, 64'(got.size()), 64'(nb));
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), 64'(got[i]), 64'(exp[i]));
  endtask

  initial begin
    bytes_t ex;
    kif.key_in = '0; kif.iv_in = '0; kif.load = 1'b0; kif.ks_ready = 1'b0;

    vecs[0] = mkvec(80'h80, 80'h0, 1'b0, -1, 0, 64);
    vecs[1] = mkvec(80'h0, 80'h0, 1'b0, -1, 0, 64);
    vecs[2] = mkvec(80'h0, 80'h0, 1'b0, 3, 10, 16);
    vecs[3] = mkvec(80'h80, 80'h0, 1'b1, -1, 0, 16);
    vecs[4] = mkvec({16'($urandom), $urandom, $urandom}, {16'($urandom), $urandom, $urandom},
                    1'b0, 7, 4, 32);
    vecs[5] = mkvec({16'($urandom), $urandom, $urandom}, {16'($urandom), $urandom, $urandom},
                    1'b1, 2, 5, 16);

    #1;
    chk("reset outputs", 64'({kif.busy, kif.ks_valid, kif.ks_byte}), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    tick();

    // load with ena low must not start anything
    kif.key_in = 80'h80; kif.load = 1'b1; ena = 1'b0;
    tick();
    kif.load = 1'b0; ena = 1'b1;
    tick(); tick();
    chk("load_without_ena", 64'({kif.busy, kif.ks_valid}), 64'd0);

    for (int v = 0; v < 6; v++) begin
      start(vecs[v].key, vecs[v].iv, vecs[v].tog, $sformatf("v%0d", v));
      collect(vecs[v].exp, vecs[v].nb, vecs[v].tog, vecs[v].stall_at, vecs[v].stall_len,
              $sformatf("v%0d", v));
    end

    // reload at byte 5 with ready held high
    start(vecs[0].key, vecs[0].iv, 1'b0, "reload_a");
    collect(vecs[0].exp, 5, 1'b0, -1, 0, "reload_a");
    chk("reload valid_before", 64'(kif.ks_valid), 64'd1);
    kif.ks_ready = 1'b1;
    start(vecs[4].key, vecs[4].iv, 1'b0, "reload_b");
    collect(vecs[4].exp, 4, 1'b0, -1, 0, "reload_b");

    // asynchronous reset in the middle of RUN
    ex = vecs[1].exp;
    start(vecs[1].key, vecs[1].iv, 1'b0, "rst_run");
    collect(ex, 3, 1'b0, -1, 0, "rst_run");
    kif.ks_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("async reset outputs", 64'({kif.busy, kif.ks_valid, kif.ks_byte}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("idle_after_reset c%0d", i), 64'({kif.busy, kif.ks_valid, kif.ks_byte}), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
